// File: rtl/periphery_pkg.sv
// periphery_pkg: shared widths, IO initiator defaults and FSM state type.
package periphery_pkg;
    localparam int IO_DATA_L         = 32;
    localparam int ADDR_TYPE_L       = 2;
    localparam int INPUT_REG_L       = 2 * IO_DATA_L;
    localparam int OUTPUT_DATA_L     = IO_DATA_L;
    localparam int IO_CMD_FIFO_DEPTH = 4;
    localparam int IO_RD_TIMEOUT     = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} io_init_state_t;
endpackage

// File: rtl/io_host_initiator_fifo.sv
// io_cmd_fifo: power-of-two command FIFO with registered occupancy count.
module io_cmd_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/io_host_initiator.sv
// io_host_initiator: queues host read/write commands and issues them as single-cycle
// strobes to the IO access block; reads block until data or timeout is returned.
module io_host_initiator import periphery_pkg::*; #(
    parameter int DATA_L     = IO_DATA_L,
    parameter int FIFO_DEPTH = IO_CMD_FIFO_DEPTH,
    parameter int RD_TIMEOUT = IO_RD_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic                     cmd_wr,
    input  logic [DATA_L-1:0]        cmd_addr,
    input  logic [DATA_L-1:0]        cmd_data,
    output logic [INPUT_REG_L-1:0]   io_in,
    output logic                     io_wr_en,
    output logic                     io_rd_en,
    input  logic [OUTPUT_DATA_L-1:0] io_rd_data,
    input  logic                     io_rd_data_vld,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output logic [DATA_L-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);
    io_init_state_t state, state_nxt;
    logic full, empty, push, pop, op_wr, timeout, err_q;
    logic [2*DATA_L:0]      head;
    logic [INPUT_REG_L-1:0] io_in_q;
    logic [CW-1:0]          cnt;
    logic [DATA_L-1:0]      data_q;

    // gating with rst keeps cmd_rdy low for the whole reset, not just after the first edge
    assign cmd_rdy = rst & ~full;
    assign push    = cmd_vld & cmd_rdy;
    assign timeout = cnt == CW'(RD_TIMEOUT - 1);
    assign io_in   = io_in_q;

    io_cmd_fifo #(.W(2*DATA_L+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_wr, cmd_addr, cmd_data}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = empty ? IDLE : ISSUE;
            ISSUE:   state_nxt = !op_wr ? WAIT_RD : (empty ? IDLE : ISSUE);
            WAIT_RD: state_nxt = (io_rd_data_vld || timeout) ? RSP : WAIT_RD;
            RSP:     state_nxt = rsp_rdy ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io_wr_en = state == ISSUE && op_wr;
        io_rd_en = state == ISSUE && !op_wr;
        rsp_vld  = state == RSP;
        rsp_data = rsp_vld ? data_q : '0;
        rsp_err  = rsp_vld & err_q;
        busy     = !empty || state != IDLE;
        pop      = !empty && (state == IDLE || (state == ISSUE && op_wr));
    end

    // data takes priority over a timeout landing in the same cycle
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            io_in_q <= '0;
            op_wr   <= 1'b0;
            cnt     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                op_wr   <= head[2*DATA_L];
                io_in_q <= INPUT_REG_L'(head[2*DATA_L-1:0]);
            end
            cnt <= state == WAIT_RD ? cnt + 1'b1 : '0;
            if (state == WAIT_RD && io_rd_data_vld) begin
                data_q <= io_rd_data[DATA_L-1:0];
                err_q  <= 1'b0;
            end else if (state == WAIT_RD && timeout) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
endmodule

// File: tb/tb_io_host_initiator.sv
// tb_io_host_initiator: directed self-checking bench for io_host_initiator.
module tb_io_host_initiator;
    import periphery_pkg::*;
    localparam int DL = IO_DATA_L;

    logic clk = 0, rst = 0, cmd_vld = 0, cmd_wr = 0, io_rd_data_vld = 0, rsp_rdy = 0;
    logic cmd_rdy, io_wr_en, io_rd_en, rsp_vld, rsp_err, busy;
    logic [DL-1:0] cmd_addr = '0, cmd_data = '0, rsp_data;
    logic [INPUT_REG_L-1:0] io_in;
    logic [OUTPUT_DATA_L-1:0] io_rd_data = '0;

    int n_checks = 0, n_fail = 0, cyc = 0, n_log = 0;
    logic [INPUT_REG_L:0] log_q [256];
    int log_cyc [256];

    io_host_initiator dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .io_in(io_in), .io_wr_en(io_wr_en),
        .io_rd_en(io_rd_en), .io_rd_data(io_rd_data), .io_rd_data_vld(io_rd_data_vld),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if ((io_wr_en || io_rd_en) && n_log < 256) begin
            log_q[n_log] = {io_wr_en, io_in};
            log_cyc[n_log] = cyc;
            n_log++;
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input logic wr, input logic [DL-1:0] a, input logic [DL-1:0] d);
        int k = 0;
        cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_vld = 1;
        while (!cmd_rdy && k < 50) begin @(negedge clk); k++; end
        n_checks++;
        if (!cmd_rdy) begin n_fail++; $display("FAIL push_accept: cmd_rdy=%b required 1 within 50 cycles", cmd_rdy); end
        @(negedge clk);
        cmd_vld = 0;
    endtask

    task automatic wait_rd();
        int k = 0;
        do begin @(negedge clk); k++; end while (!io_rd_en && k < 60);
        n_checks++;
        if (!io_rd_en) begin n_fail++; $display("FAIL wait_rd_en: io_rd_en=%b required 1 within 60 cycles", io_rd_en); end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({io_in, io_wr_en, io_rd_en, rsp_vld, rsp_data, rsp_err, busy, cmd_rdy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: io_in=%h wr=%b rd=%b rsp_vld=%b rsp_data=%h err=%b busy=%b rdy=%b required all 0",
                io_in, io_wr_en, io_rd_en, rsp_vld, rsp_data, rsp_err, busy, cmd_rdy);
        end
        @(negedge clk); rst = 1; #1;
        n_checks++;
        if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: rdy=%b busy=%b required 1 0", cmd_rdy, busy); end
        @(negedge clk);
    endtask

    task automatic test_write();
        cmd_wr = 1; cmd_addr = 32'h0000_0010; cmd_data = 32'h0000_00A5; cmd_vld = 1;
        n_checks++;
        if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_rdy: got %b required 1", cmd_rdy); end
        @(negedge clk); cmd_vld = 0;
        n_checks++;
        if (io_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_n1: io_wr_en=%b required 0", io_wr_en); end
        @(negedge clk);
        n_checks++;
        if (io_wr_en !== 1'b1 || io_rd_en !== 1'b0 || io_in !== {32'h0000_0010, 32'h0000_00A5} || rsp_vld !== 1'b0) begin
            n_fail++; $display("FAIL wr_n2: wr=%b rd=%b io_in=%h rsp_vld=%b required 1 0 %h 0", io_wr_en, io_rd_en, io_in, rsp_vld, {32'h0000_0010, 32'h0000_00A5});
        end
        @(negedge clk);
        n_checks++;
        if (io_wr_en !== 1'b0 || io_in !== {32'h0000_0010, 32'h0000_00A5} || rsp_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_n3: wr=%b io_in=%h rsp_vld=%b busy=%b required 0 held 0 0", io_wr_en, io_in, rsp_vld, busy);
        end
    endtask

    task automatic test_read();
        push(0, 32'h4000_0020, 32'h0);
        wait_rd();
        n_checks++;
        if (io_in[DL +: DL] !== 32'h4000_0020) begin n_fail++; $display("FAIL rd_addr: got %h required 40000020", io_in[DL +: DL]); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rd_early: rsp_vld=%b required 0", rsp_vld); end
        @(negedge clk); io_rd_data = 32'h0000_1234; io_rd_data_vld = 1;
        @(negedge clk); io_rd_data = '0; io_rd_data_vld = 0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== 32'h0000_1234 || rsp_err !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL rd_hold%0d: vld=%b data=%h err=%b busy=%b required 1 00001234 0 1", i, rsp_vld, rsp_data, rsp_err, busy);
            end
            if (i < 5) @(negedge clk);
        end
        rsp_rdy = 1; @(negedge clk); rsp_rdy = 0;
        n_checks++;
        if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rd_taken: rsp_vld=%b required 0", rsp_vld); end
    endtask

    task automatic test_timeout();
        io_rd_data = 32'hDEAD_BEEF;
        push(0, 32'h8000_0030, 32'h0);
        wait_rd();
        repeat (16) @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL to_early: rsp_vld=%b required 0", rsp_vld); end
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            n_fail++; $display("FAIL to_rsp: vld=%b err=%b data=%h required 1 1 0", rsp_vld, rsp_err, rsp_data);
        end
        rsp_rdy = 1; @(negedge clk); rsp_rdy = 0;
        push(0, 32'h8000_0034, 32'h0);
        wait_rd();
        repeat (16) @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL to_last_early: rsp_vld=%b required 0", rsp_vld); end
        io_rd_data = 32'h0000_BEEF; io_rd_data_vld = 1;
        @(negedge clk); io_rd_data_vld = 0; io_rd_data = '0;
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL to_last_data: vld=%b err=%b data=%h required 1 0 0000beef", rsp_vld, rsp_err, rsp_data);
        end
        rsp_rdy = 1; @(negedge clk); rsp_rdy = 0;
    endtask

    task automatic test_mixed();
        int base = n_log;
        io_rd_data = 32'h0000_5555; io_rd_data_vld = 1;
        @(negedge clk); io_rd_data_vld = 0; io_rd_data = '0;
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b0 || busy !== 1'b0 || n_log !== base) begin
            n_fail++; $display("FAIL stray_vld: rsp_vld=%b busy=%b strobes=%0d required 0 0 0", rsp_vld, busy, n_log - base);
        end
        push(1, 32'h0000_0100, 32'h0000_00C3);
        push(0, 32'h4000_0104, 32'h0);
        wait_rd();
        @(negedge clk); io_rd_data = 32'h0000_0777; io_rd_data_vld = 1;
        @(negedge clk); io_rd_data_vld = 0; io_rd_data = '0;
        n_checks++;
        if (rsp_vld !== 1'b1 || rsp_data !== 32'h0000_0777 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL mixed_rsp: vld=%b data=%h err=%b required 1 00000777 0", rsp_vld, rsp_data, rsp_err);
        end
        n_checks++;
        if (n_log !== base + 2 || log_q[base] !== {1'b1, 32'h0000_0100, 32'h0000_00C3} ||
            log_q[base+1] !== {1'b0, 32'h4000_0104, 32'h0} || log_cyc[base+1] !== log_cyc[base] + 1) begin
            n_fail++; $display("FAIL mixed_order: n=%0d first=%h second=%h dcyc=%0d required 2 wr-then-rd 1 cycle apart",
                n_log - base, log_q[base], log_q[base+1], log_cyc[base+1] - log_cyc[base]);
        end
        rsp_rdy = 1; @(negedge clk); rsp_rdy = 0;
    endtask

    task automatic test_back_to_back();
        int base;
        push(0, 32'h0000_0200, 32'h0);
        wait_rd();
        repeat (17) @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp: rsp_vld=%b required 1", rsp_vld); end
        base = n_log;
        for (int i = 0; i < 4; i++) push(1, 32'h0000_0300 + i, 32'h0000_1000 + i);
        n_checks++;
        if (cmd_rdy !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_full: rdy=%b busy=%b required 0 1", cmd_rdy, busy); end
        rsp_rdy = 1;
        push(1, 32'h0000_0304, 32'h0000_1004);
        rsp_rdy = 0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (n_log !== base + 5) begin n_fail++; $display("FAIL b2b_count: strobes=%0d required 5", n_log - base); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (log_q[base+i] !== {1'b1, 32'h0000_0300 + i, 32'h0000_1000 + i} || log_cyc[base+i] !== log_cyc[base] + i) begin
                n_fail++; $display("FAIL b2b_w%0d: entry=%h dcyc=%0d required %h %0d", i, log_q[base+i], log_cyc[base+i] - log_cyc[base],
                    {1'b1, 32'h0000_0300 + i, 32'h0000_1000 + i}, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        push(0, 32'h4000_0400, 32'h0);
        wait_rd();
        push(1, 32'h0000_0404, 32'h1);
        push(1, 32'h0000_0408, 32'h2);
        base = n_log;
        n_checks++;
        if (busy !== 1'b1 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: busy=%b rdy=%b required 1 1", busy, cmd_rdy); end
        #2 rst = 0; io_rd_data = 32'h0000_9999; io_rd_data_vld = 1; #1;
        n_checks++;
        if ({io_in, io_wr_en, io_rd_en, rsp_vld, rsp_data, rsp_err, busy, cmd_rdy} !== '0) begin
            n_fail++; $display("FAIL mid_reset: io_in=%h wr=%b rd=%b rsp_vld=%b data=%h err=%b busy=%b rdy=%b required all 0",
                io_in, io_wr_en, io_rd_en, rsp_vld, rsp_data, rsp_err, busy, cmd_rdy);
        end
        @(negedge clk); rst = 1; #1;
        n_checks++;
        if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_release: rdy=%b required 1", cmd_rdy); end
        repeat (3) @(negedge clk);
        io_rd_data_vld = 0; io_rd_data = '0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_log !== base || rsp_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: strobes=%0d rsp_vld=%b busy=%b required 0 0 0", n_log - base, rsp_vld, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_mixed();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
